// File: rtl/fm_wm_adj_aggregator.sv
// Builds ADJ*(FM*WM) row by row (self-loop plus undirected COO edges), then streams
// the aggregated rows to the readout arg-max with an alternating read/write strobe pair.
module fm_wm_adj_aggregator #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int DOT_PROD_WIDTH        = 16,
    parameter int NUM_OF_EDGES          = 6,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int COUNTER_EDGE_WIDTH    = $clog2(NUM_OF_EDGES)
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [NUM_OF_EDGES-1:0][COUNTER_FEATURE_WIDTH-1:0] coo_src,
    input  logic [NUM_OF_EDGES-1:0][COUNTER_FEATURE_WIDTH-1:0] coo_dst,
    output logic [COUNTER_FEATURE_WIDTH-1:0]                 read_fm_wm_row,
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]       fm_wm_row_in,
    input  logic [COUNTER_FEATURE_WIDTH-1:0]                 read_fm_wm_adj_row,
    output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]       fm_wm_adj_row_out,
    output logic                                             argmax_read,
    output logic                                             argmax_write,
    output logic                                             busy,
    output logic                                             done
);
    localparam int CFW = COUNTER_FEATURE_WIDTH;
    localparam int CEW = COUNTER_EDGE_WIDTH;

    localparam logic [CFW:0]   NROWS     = (CFW+1)'(FEATURE_ROWS);
    localparam logic [CFW-1:0] LAST_ROW  = CFW'(FEATURE_ROWS - 1);
    localparam logic [CEW-1:0] LAST_EDGE = CEW'(NUM_OF_EDGES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_EDGE_A   = 3'd2;
    localparam logic [2:0] S_EDGE_B   = 3'd3;
    localparam logic [2:0] S_STREAM_R = 3'd4;
    localparam logic [2:0] S_STREAM_W = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

    logic [2:0]     state_q, state_d;
    logic [CFW-1:0] idx_q, idx_d;     // INIT row index, reused as stream row index
    logic [CEW-1:0] edge_q, edge_d;
    row_t           acc_q [FEATURE_ROWS];

    logic [CFW-1:0] cur_src, cur_dst, wr_row;
    logic           edge_ok, wr_en, wr_accum;
    row_t           wr_data;

    assign cur_src = coo_src[edge_q];
    assign cur_dst = coo_dst[edge_q];
    assign edge_ok = ({1'b0, cur_src} < NROWS) && ({1'b0, cur_dst} < NROWS);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        edge_d  = edge_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                end
            end
            S_INIT: begin
                if (idx_q == LAST_ROW) begin
                    state_d = S_EDGE_A;
                    idx_d   = '0;
                    edge_d  = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_EDGE_A: state_d = S_EDGE_B;
            S_EDGE_B: begin
                if (edge_q == LAST_EDGE) begin
                    state_d = S_STREAM_R;
                    idx_d   = '0;
                end else begin
                    state_d = S_EDGE_A;
                    edge_d  = edge_q + 1'b1;
                end
            end
            S_STREAM_R: state_d = S_STREAM_W;
            S_STREAM_W: begin
                if (idx_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM_R;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // EDGE_A adds the dst row into src, EDGE_B the src row into dst; the source
    // memory is read at the opposite endpoint so a self-edge lands twice.
    always_comb begin
        wr_en          = 1'b0;
        wr_accum       = 1'b0;
        wr_row         = '0;
        read_fm_wm_row = '0;
        case (state_q)
            S_INIT: begin
                wr_en          = 1'b1;
                wr_row         = idx_q;
                read_fm_wm_row = idx_q;
            end
            S_EDGE_A: begin
                wr_en          = edge_ok;
                wr_accum       = 1'b1;
                wr_row         = cur_src;
                read_fm_wm_row = cur_dst;
            end
            S_EDGE_B: begin
                wr_en          = edge_ok;
                wr_accum       = 1'b1;
                wr_row         = cur_dst;
                read_fm_wm_row = cur_src;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_data = '0;
        if (wr_en) begin
            for (int c = 0; c < WEIGHT_COLS; c++)
                wr_data[c] = fm_wm_row_in[c] + (wr_accum ? acc_q[wr_row][c] : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            edge_q  <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++)
                acc_q[r] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            edge_q  <= edge_d;
            if (wr_en)
                acc_q[wr_row] <= wr_data;
        end
    end

    always_comb begin
        fm_wm_adj_row_out = '0;
        if ({1'b0, read_fm_wm_adj_row} < NROWS)
            fm_wm_adj_row_out = acc_q[read_fm_wm_adj_row];
    end

    assign argmax_read  = (state_q == S_STREAM_R);
    assign argmax_write = (state_q == S_STREAM_W);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_fm_wm_adj_aggregator.sv
// Directed + randomized checks of the aggregator against a sum-over-edges reference.
module tb_fm_wm_adj_aggregator;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [5:0][2:0]  src, dst;
    logic [2:0]       rd_row, adj_sel;
    logic [2:0][15:0] fm_in, adj_out;
    logic             ar, aw, busy, done;
    logic [15:0]      fm [6][3];
    int               tests = 0;
    int               fails = 0;

    fm_wm_adj_aggregator dut (
        .clk(clk), .reset(reset), .start(start),
        .coo_src(src), .coo_dst(dst),
        .read_fm_wm_row(rd_row), .fm_wm_row_in(fm_in),
        .read_fm_wm_adj_row(adj_sel), .fm_wm_adj_row_out(adj_out),
        .argmax_read(ar), .argmax_write(aw), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FM*WM result memory: combinational read, zero outside the node range
    always_comb begin
        fm_in = '0;
        if (rd_row < 3'd6)
            for (int c = 0; c < 3; c++) fm_in[c] = fm[rd_row][c];
    end

    // Reference: own row plus the row of every neighbour across each in-range edge
    function automatic logic [47:0] exp_row(input int n);
        logic [2:0][15:0] r;
        r = '0;
        if (n < 6) begin
            for (int c = 0; c < 3; c++) begin
                r[c] = fm[n][c];
                for (int e = 0; e < 6; e++) begin
                    if (src[e] < 3'd6 && dst[e] < 3'd6) begin
                        if (int'(src[e]) == n) r[c] = r[c] + fm[dst[e]][c];
                        if (int'(dst[e]) == n) r[c] = r[c] + fm[src[e]][c];
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag, input bit expect_zero);
        for (int n = 0; n < 8; n++) begin
            adj_sel = 3'(n);
            #1;
            chk($sformatf("%s_row%0d", tag, n), 64'(adj_out), expect_zero ? 64'd0 : 64'(exp_row(n)));
        end
    endtask

    task automatic rand_graph();
        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 3; c++) fm[i][c] = 16'($urandom);
        for (int e = 0; e < 6; e++) begin
            src[e] = 3'($urandom_range(0, 7));
            dst[e] = ($urandom_range(0, 3) == 0) ? src[e] : 3'($urandom_range(0, 7));
        end
    endtask

    // One full pass with a downstream row counter advanced on argmax_write
    task automatic run_pass(input string tag, input int restart_cyc);
        int done_cyc = 0, nr = 0, nw = 0, first_r = 0, bad_alt = 0, busy_bad = 0, cnt = 0;
        bit exp_rd = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        adj_sel = '0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_cyc);
            if (!busy) busy_bad++;
            if (ar && aw) bad_alt++;
            if (ar) begin
                if (!exp_rd) bad_alt++;
                exp_rd = 1'b0;
                nr++;
                if (first_r == 0) first_r = cyc;
                chk($sformatf("%s_stream%0d", tag, cnt), 64'(adj_out), 64'(exp_row(cnt)));
            end
            if (aw) begin
                if (exp_rd) bad_alt++;
                exp_rd = 1'b1;
                nw++;
                cnt++;
                adj_sel = 3'(cnt);
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'd31);
        chk({tag, "_reads"}, 64'(nr), 64'd6);
        chk({tag, "_writes"}, 64'(nw), 64'd6);
        chk({tag, "_first_read"}, 64'(first_r), 64'd19);
        chk({tag, "_alternate"}, 64'(bad_alt), 64'd0);
        chk({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'({busy, done, ar, aw, rd_row}), 64'd0);
        sweep(tag, 1'b0);
    endtask

    initial begin
        int strobes;
        int wcyc;
        src = '1; dst = '1; adj_sel = '0;
        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 3; c++) fm[i][c] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_outputs", 64'({busy, done, ar, aw, rd_row}), 64'd0);
        sweep("reset", 1'b1);
        strobes = 0;
        repeat (50) begin
            @(negedge clk);
            if (ar || aw || busy || done) strobes++;
        end
        chk("idle_no_strobes", 64'(strobes), 64'd0);

        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 3; c++) fm[i][c] = 16'(i * (c + 1));
        src = '1; dst = '1;
        src[0] = 3'd0; dst[0] = 3'd1;
        run_pass("single", 0);

        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 3; c++) fm[i][c] = 16'd1;
        for (int e = 0; e < 6; e++) begin
            src[e] = 3'(e);
            dst[e] = 3'((e + 1) % 6);
        end
        run_pass("ring", 0);
        adj_sel = 3'd4;
        #1 chk("ring_row4_const", 64'(adj_out), {16'd0, 16'd3, 16'd3, 16'd3});

        src = '1; dst = '1;
        src[0] = 3'd2; dst[0] = 3'd2;
        fm[2][0] = 16'hFFFF; fm[2][1] = 16'd5; fm[2][2] = 16'd0;
        run_pass("selfwrap", 0);
        adj_sel = 3'd2;
        #1 chk("selfwrap_row2_const", 64'(adj_out), {16'd0, 16'd0, 16'd15, 16'hFFFD});

        rand_graph();
        run_pass("restart_ignored", 7);

        rand_graph();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wcyc = 0;
        for (int cyc = 1; cyc <= 40 && wcyc == 0; cyc++) begin
            @(negedge clk);
            if (aw) wcyc = cyc;
        end
        chk("abort_first_write", 64'(wcyc), 64'd20);
        reset = 1'b0;
        #1;
        chk("abort_outputs", 64'({busy, done, ar, aw, rd_row}), 64'd0);
        sweep("abort", 1'b1);
        @(negedge clk);
        reset = 1'b1;
        strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (ar || aw || busy || done) strobes++;
        end
        chk("abort_quiet", 64'(strobes), 64'd0);
        run_pass("after_abort", 0);

        for (int k = 0; k < 4; k++) begin
            rand_graph();
            run_pass($sformatf("rand%0d", k), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fm_wm_adj_aggregator.md
Name: fm_wm_adj_aggregator

Overview:
- Aggregation stage directly upstream of the readout arg-max.
- Builds each row of ADJ·(FM·WM): starts from the node's own FM·WM row (self-loop), then adds the FM·WM rows of its neighbours for every undirected COO edge.
- Then streams the aggregated rows to the arg-max, using the read/write strobe pair that the arg-max row counter expects.

Parameters:
- FEATURE_ROWS, 6, number of nodes/rows.
- WEIGHT_COLS, 3, number of classes (row width in elements).
- DOT_PROD_WIDTH, 16, element width.
- NUM_OF_EDGES, 6, number of COO edges.
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width.
- COUNTER_EDGE_WIDTH, $clog2(NUM_OF_EDGES), edge index width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, begin an aggregation pass; sampled only in IDLE.
- coo_src, input, [COUNTER_FEATURE_WIDTH-1:0] x NUM_OF_EDGES, edge endpoint A; held stable from start until done.
- coo_dst, input, [COUNTER_FEATURE_WIDTH-1:0] x NUM_OF_EDGES, edge endpoint B; held stable from start until done.
- read_fm_wm_row, output, COUNTER_FEATURE_WIDTH, address into the FM·WM result memory.
- fm_wm_row_in, input, [DOT_PROD_WIDTH-1:0] x WEIGHT_COLS, FM·WM row at read_fm_wm_row; combinational, same cycle.
- read_fm_wm_adj_row, input, COUNTER_FEATURE_WIDTH, row select driven by the downstream row counter.
- fm_wm_adj_row_out, output, [DOT_PROD_WIDTH-1:0] x WEIGHT_COLS, aggregated row at read_fm_wm_adj_row (combinational).
- argmax_read, output, 1, row-valid strobe to downstream.
- argmax_write, output, 1, row-advance strobe to downstream.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (asserted low, asynchronous):
  - State goes to IDLE; all accumulators cleared to 0.
  - read_fm_wm_row, argmax_read, argmax_write, busy and done are all 0.
  - Reset mid-pass aborts the pass immediately; no partial strobes follow.
- Storage: acc[FEATURE_ROWS][WEIGHT_COLS], each DOT_PROD_WIDTH wide. Sums wrap modulo 2^DOT_PROD_WIDTH; no saturation.
- IDLE:
  - start=1 moves to INIT with index i=0.
  - start while not in IDLE is ignored.
- INIT, FEATURE_ROWS cycles:
  - read_fm_wm_row=i; acc[i] <= fm_wm_row_in (overwrite, not add).
  - After i=FEATURE_ROWS-1, go to EDGE_A with edge index e=0.
- EDGE_A, 1 cycle per edge:
  - read_fm_wm_row=coo_dst[e]; acc[coo_src[e]] += fm_wm_row_in. Then go to EDGE_B.
- EDGE_B, 1 cycle per edge:
  - read_fm_wm_row=coo_src[e]; acc[coo_dst[e]] += fm_wm_row_in.
  - Then e++ and back to EDGE_A, or go to STREAM_R with r=0 after the last edge.
- Self-edge (src==dst): both additions apply, so the row gains 2×its own FM·WM row.
- Out-of-range edge index (src or dst ≥ FEATURE_ROWS): both additions for that edge are suppressed; its two cycles are still consumed.
- STREAM_R: argmax_read=1 for one cycle, then go to STREAM_W.
- STREAM_W:
  - argmax_write=1 for one cycle; r++.
  - Then go to STREAM_R, or to DONE after r=FEATURE_ROWS-1.
  - argmax_read and argmax_write are never high in the same cycle.
- DONE: done=1 for one cycle, then go to IDLE. acc keeps its contents until the next start or reset.
- fm_wm_adj_row_out:
  - Always equals acc[read_fm_wm_adj_row], including in IDLE.
  - Is all-zero when read_fm_wm_adj_row ≥ FEATURE_ROWS.
- read_fm_wm_row is 0 outside INIT/EDGE_A/EDGE_B.
- Latency: done is high FEATURE_ROWS + 2·NUM_OF_EDGES + 2·FEATURE_ROWS + 1 cycles after the start-sampling edge (31 with defaults). busy is high for the whole interval.

Test Plan:
- Reset then idle: reset low for 2 cycles, then high → every output 0 and fm_wm_adj_row_out all-zero for all selects; start never pulsed → no strobes for 50 cycles.
- Single edge:
  - Setup: FM·WM row i = {i, 2i, 3i}; edges (0,1) plus five edges (7,7) (out of range).
  - Required: row0 = row1 = {1,2,3}; rows 2..5 = {i,2i,3i}.
  - Timing: done in cycle 31; exactly 6 argmax_read and 6 argmax_write pulses, alternating, first argmax_read in cycle 19.
- Ring graph:
  - Setup: edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0); all FM·WM rows {1,1,1}.
  - Required: every aggregated row = {3,3,3}.
- Self-loop and wrap:
  - Setup: edge (2,2), other edges out of range; row2 = {16'hFFFF, 5, 0}.
  - Required: row2 = {16'hFFFD, 15, 0}, i.e. 3× with modular wrap.
- Start ignored and reset abort:
  - start pulsed again during EDGE_A → no restart; completion still in cycle 31.
  - Separate pass: reset asserted during STREAM_W → strobes stop immediately; acc reads zero; a new start gives a full correct pass.
- Downstream integration: drive read_fm_wm_adj_row from a counter incremented on argmax_write → the row captured on each argmax_read matches that row's expected value for rows 0..5.
